// File: rtl/host_wb_loader_pkg.sv
// Shared types and helpers for the host-to-Wishbone program loader.
//   state_t         loader FSM states
//   WB_CTI_CLASSIC  cycle type for classic single cycles
//   WB_BTE_LINEAR   burst type (unused by classic cycles, driven to zero)
//   sel_from_count  byte-select mask for a word holding byte_cnt leading bytes
package host_wb_loader_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        WRITE,
        WAIT_NEXT,
        DONE,
        ERROR
    } state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Bytes are packed big-endian, so filled lanes start at the top of the word.
    function automatic logic [3:0] sel_from_count(input logic [2:0] byte_cnt);
        logic [3:0] sel;
        case (byte_cnt)
            3'd1:    sel = 4'b1000;
            3'd2:    sel = 4'b1100;
            3'd3:    sel = 4'b1110;
            3'd4:    sel = 4'b1111;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/host_byte_packer.sv
// Collects host bytes into a 32-bit big-endian word.
//   clk, rst_n  clock and asynchronous active-low reset
//   data        host byte
//   valid       host strobe; a rising edge accepts data while enable is high
//   enable      accept bytes (loader is collecting)
//   clear       empty the word buffer and byte count
//   word        buffer contents including any byte accepted this cycle
//   byte_cnt    byte count including any byte accepted this cycle (0..4)
//   word_full   byte_cnt has reached four
//   ack_data    one-cycle pulse in the cycle after each accepted byte
module host_byte_packer
    import host_wb_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    input  logic        valid,
    input  logic        enable,
    input  logic        clear,
    output logic [31:0] word,
    output logic [2:0]  byte_cnt,
    output logic        word_full,
    output logic        ack_data
);

    logic        valid_prev;
    logic        accept;
    logic [31:0] buffer;
    logic [2:0]  count;

    // word/byte_cnt look through this cycle's acceptance so the loader can
    // launch the bus write on the same edge that takes the last byte.
    always_comb begin
        accept   = enable && valid && !valid_prev && (count != 3'd4);
        word     = buffer;
        byte_cnt = count;
        if (accept) begin
            unique case (count[1:0])
                2'd0: word[31:24] = data;
                2'd1: word[23:16] = data;
                2'd2: word[15:8]  = data;
                2'd3: word[7:0]   = data;
            endcase
            byte_cnt = count + 3'd1;
        end
        word_full = (byte_cnt == 3'd4);
    end

    // The edge detector samples valid in every state, so edges seen while
    // the loader is busy are consumed and never replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_prev <= 1'b0;
            ack_data   <= 1'b0;
            buffer     <= 32'h0;
            count      <= 3'd0;
        end else begin
            valid_prev <= valid;
            ack_data   <= accept;
            if (clear) begin
                buffer <= 32'h0;
                count  <= 3'd0;
            end else begin
                buffer <= word;
                count  <= byte_cnt;
            end
        end
    end

endmodule

// File: rtl/host_wb_loader.sv
// Wishbone B3 master that loads a host program image into memory, packing
// host bytes big-endian into words written from BASE_ADDR upward, and holds
// the CPU in reset until the image is complete.
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   data_i, valid_i             host byte and strobe (rising edge accepts)
//   done_i                      host has sent the last byte
//   next_i                      host releases the word acknowledge
//   ack_data_o                  pulse per accepted byte
//   ack_o                       word committed, held until next_i
//   cpu_rst_o                   CPU reset hold
//   err_o                       sticky bus error / timeout
//   word_cnt_o                  words written (wraps)
//   wb_*                        Wishbone master port, classic write cycles only
module host_wb_loader
    import host_wb_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        done_i,
    input  logic        next_i,
    output logic        ack_data_o,
    output logic        ack_o,
    output logic        cpu_rst_o,
    output logic        err_o,
    output logic [23:0] word_cnt_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [31:0] addr, addr_next;
    logic [15:0] tmo_cnt, tmo_next;
    logic        flush_pending, flush_next;
    logic        ack_next, err_next, cpu_rst_next, cyc_next;
    logic [23:0] word_cnt_next;
    logic [31:0] adr_next, dat_next;
    logic [3:0]  sel_next;

    logic [31:0] pack_word;
    logic [2:0]  pack_cnt;
    logic        pack_full;
    logic        pack_clear;

    // Write data is never read back.
    logic unused_dat;
    assign unused_dat = ^wb_dat_i;

    assign wb_cti_o = WB_CTI_CLASSIC;
    assign wb_bte_o = WB_BTE_LINEAR;

    host_byte_packer u_packer (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .data      (data_i),
        .valid     (valid_i),
        .enable    (state == COLLECT),
        .clear     (pack_clear),
        .word      (pack_word),
        .byte_cnt  (pack_cnt),
        .word_full (pack_full),
        .ack_data  (ack_data_o)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= COLLECT;
            addr          <= BASE_ADDR;
            tmo_cnt       <= 16'h0;
            flush_pending <= 1'b0;
            ack_o         <= 1'b0;
            err_o         <= 1'b0;
            cpu_rst_o     <= 1'b1;
            word_cnt_o    <= 24'h0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= 32'h0;
            wb_dat_o      <= 32'h0;
            wb_sel_o      <= 4'h0;
        end else begin
            state         <= state_next;
            addr          <= addr_next;
            tmo_cnt       <= tmo_next;
            flush_pending <= flush_next;
            ack_o         <= ack_next;
            err_o         <= err_next;
            cpu_rst_o     <= cpu_rst_next;
            word_cnt_o    <= word_cnt_next;
            wb_cyc_o      <= cyc_next;
            wb_stb_o      <= cyc_next;
            wb_we_o       <= cyc_next;
            wb_adr_o      <= adr_next;
            wb_dat_o      <= dat_next;
            wb_sel_o      <= sel_next;
        end
    end

    // Byte acceptance is folded in first, so done_i sees the updated count.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (pack_full || (done_i && pack_cnt != 3'd0)) begin
                    state_next = WRITE;
                end else if (done_i) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                if (wb_err_i) begin
                    state_next = ERROR;
                end else if (wb_ack_i) begin
                    state_next = WAIT_NEXT;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ERROR;
                end
            end
            WAIT_NEXT: begin
                if (next_i) begin
                    state_next = (flush_pending || done_i) ? DONE : COLLECT;
                end
            end
            default: state_next = state;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        addr_next     = addr;
        tmo_next      = tmo_cnt;
        flush_next    = flush_pending;
        ack_next      = ack_o;
        err_next      = err_o;
        word_cnt_next = word_cnt_o;
        cyc_next      = wb_cyc_o;
        adr_next      = wb_adr_o;
        dat_next      = wb_dat_o;
        sel_next      = wb_sel_o;
        pack_clear    = 1'b0;
        cpu_rst_next  = (state_next != DONE);
        case (state)
            COLLECT: begin
                if (state_next == WRITE) begin
                    cyc_next   = 1'b1;
                    adr_next   = addr;
                    dat_next   = pack_word;
                    sel_next   = sel_from_count(pack_cnt);
                    flush_next = done_i;
                    tmo_next   = 16'h0;
                end
            end
            WRITE: begin
                if (state_next == ERROR) begin
                    cyc_next = 1'b0;
                    adr_next = 32'h0;
                    dat_next = 32'h0;
                    sel_next = 4'h0;
                    err_next = 1'b1;
                end else if (state_next == WAIT_NEXT) begin
                    cyc_next      = 1'b0;
                    adr_next      = 32'h0;
                    dat_next      = 32'h0;
                    sel_next      = 4'h0;
                    addr_next     = addr + 32'd4;
                    word_cnt_next = word_cnt_o + 24'd1;
                    pack_clear    = 1'b1;
                    ack_next      = 1'b1;
                end else begin
                    tmo_next = tmo_cnt + 16'd1;
                end
            end
            WAIT_NEXT: begin
                if (next_i) begin
                    ack_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/host_wb_loader.md
Name: host_wb_loader

Overview:
- Wishbone B3 master that loads a program image from the external host into main memory, one byte at a time, before the CPU starts.
- Packs host bytes big-endian into 32-bit words and writes each word to consecutive addresses from BASE_ADDR.
- Holds the CPU in reset until the image is complete.
- Occupies a master port on the existing Wishbone interconnect; its cpu_rst_o is ORed into the CPU reset.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first word written.
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i/wb_err_i per write; range 1..65535.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- data_i  in  8  host byte.
- valid_i  in  1  host byte strobe; a byte is accepted on the rising edge of valid_i.
- done_i  in  1  host has sent the last byte (level).
- next_i  in  1  host releases a word acknowledge.
- ack_data_o  out  1  one-cycle pulse per accepted byte.
- ack_o  out  1  word committed to memory; held until next_i.
- cpu_rst_o  out  1  CPU reset hold.
- err_o  out  1  bus error or timeout; sticky.
- word_cnt_o  out  24  number of words written, wraps.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cti_o  out  3  Wishbone cycle type.
- wb_bte_o  out  2  Wishbone burst type.
- wb_dat_i  in  32  Wishbone read data; ignored.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- Reset (asynchronous, on wb_rst_n_i low), independent of state, including mid-transfer:
  - cpu_rst_o=1; all other outputs 0.
  - Internal state: addr=BASE_ADDR, byte_cnt=0, word buffer=0, valid_i history=0, state=COLLECT.
- All outputs are registered.
- wb_cti_o is always 3'b000 and wb_bte_o is always 2'b00 (classic single cycles).
- COLLECT:
  - A rising edge of valid_i (valid_i=1, previous sample 0) accepts data_i into lane byte_cnt. Lane 0 is bits[31:24], lane 3 is bits[7:0].
  - ack_data_o pulses high for exactly one cycle, in the cycle after acceptance.
  - valid_i held high does not accept further bytes.
  - On acceptance of lane 3 → WRITE with sel=4'hF. wb_cyc_o/wb_stb_o rise in the cycle after the accepting edge.
  - done_i=1 with byte_cnt=0 and no edge → DONE.
  - done_i=1 with byte_cnt>0 → WRITE (flush) with sel covering the filled lanes only: 1 byte=4'b1000, 2=4'b1100, 3=4'b1110. Unfilled lanes drive 0. flush_pending is set.
  - valid_i edge and done_i in the same cycle: the byte is accepted first, then done_i is evaluated with the updated count. If that completes a full word, it is a normal write with flush_pending set.
- WRITE:
  - Drives wb_cyc_o=wb_stb_o=wb_we_o=1, wb_adr_o=addr, wb_dat_o=buffer.
  - wb_ack_i: drop cyc/stb/we in the same registered update, addr+=4 (wraps mod 2^32), word_cnt+=1, byte_cnt=0, buffer=0, ack_o=1 → WAIT_NEXT.
  - wb_err_i, or TIMEOUT cycles elapsed with neither response → drop cyc/stb, err_o=1 → ERROR.
  - wb_ack_i and wb_err_i asserted together: err_o wins.
  - valid_i edges during WRITE and WAIT_NEXT are ignored, with no ack_data_o. The edge detector keeps sampling, so the host must re-toggle valid_i.
- WAIT_NEXT:
  - ack_o stays 1 until next_i=1 is sampled.
  - Then ack_o=0 and the block goes → DONE if flush_pending or done_i=1, else → COLLECT.
- DONE: cpu_rst_o=0. Terminal until reset; all inputs are ignored.
- ERROR: cpu_rst_o=1, err_o=1. Terminal until reset.
- Throughput: the minimum write latency is 1 cycle after the 4th byte edge, plus the slave acknowledge time.

Decomposition:
- Package host_wb_loader_pkg:
  - State enum: COLLECT, WRITE, WAIT_NEXT, DONE, ERROR.
  - Constants WB_CTI_CLASSIC=3'b000 and WB_BTE_LINEAR=2'b00.
  - Function sel_from_count(byte_cnt) returning the sel mask.
- One sub-module, host_byte_packer:
  - valid_i edge detect, lane shift, byte_cnt and ack_data_o pulse.
  - Exposes word_full, byte_cnt and word.
- FSM, address counter, timeout counter and Wishbone drive live in the top.

Test Plan:
- Basic load: after reset, send bytes DE AD BE EF, slave acks in 2 cycles → one write with adr=0x0, dat=0xDEADBEEF, sel=F; 4 ack_data_o pulses; ack_o=1 until next_i; word_cnt_o=1.
- Two words then done: send 8 bytes, pulse next_i after each word, assert done_i with byte_cnt=0 → writes at 0x0 and 0x4; cpu_rst_o falls the cycle after done_i is sampled.
- Partial flush: send 01 02 then done_i → write adr=0x0, dat=0x01020000, sel=4'b1100; after next_i → DONE, cpu_rst_o=0.
- Simultaneous valid edge and done_i on the 3rd byte AA → sel=4'b1110 and the byte is included.
- Bus error and timeout:
  - wb_err_i on the first write → err_o=1, cpu_rst_o stays 1, no ack_o.
  - Separately, with TIMEOUT=4 and no slave response → err_o=1 exactly 4 cycles after wb_stb_o rose.
- Reset mid-write: assert wb_rst_n_i low while wb_stb_o=1 → wb_cyc_o/wb_stb_o=0 immediately (async), cpu_rst_o=1; after release, the next load restarts at BASE_ADDR with word_cnt_o=0.
